display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit seven-segment display. It drives one shared BCD-to-segment decoder with a single 4-bit digit and cycles active-low digit enables across NUM_DIGITS positions. Between positions it inserts guard (all-off) intervals to prevent ghosting. New display values are double-buffered and committed only at frame boundaries so no digit tears mid-frame. Optional leading-zero suppression and per-digit blanking are supported.

---
 rtl/display_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed seven-segment scan controller with guard
//               intervals, frame-synchronous double buffering and blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick,
    output logic                    load_ack
);

    localparam int MAX_CYC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] C_ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        GUARD  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic                    pend_q;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [4*NUM_DIGITS-1:0] active_d;
    logic [3:0]              digit_d;
    logic [NUM_DIGITS-1:0]   dark_d;
    logic                    guard_done;
    logic                    active_done;
    logic                    boundary;
    logic                    commit;
    logic                    zero_run;

    always_comb begin
        guard_done  = (state_q == GUARD)  && (cnt_q == C_GUARD_LAST);
        active_done = (state_q == ACTIVE) && (cnt_q == C_ON_LAST);
        idx_d       = (idx_q == C_IDX_LAST) ? '0 : idx_q + 1'b1;
        boundary    = guard_done && (idx_q == C_IDX_LAST);
        commit      = boundary && (load || pend_q);

        // A load on the boundary edge itself beats anything still pending.
        active_d = active_q;
        if (boundary && load) begin
            active_d = digits_in;
        end else if (boundary && pend_q) begin
            active_d = pending_q;
        end

        digit_d = active_d[{idx_d, 2'b00} +: 4];

        // Walk from the most significant digit down; a digit is a leading
        // zero while every digit at or above it is zero.
        zero_run = 1'b1;
        dark_d   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && (active_d[4*i +: 4] == 4'd0);
            dark_d[i] = blank_mask[i] || (lz_en && (i >= 1) && zero_run);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GUARD;
            cnt_q      <= '0;
            idx_q      <= C_IDX_LAST;
            pending_q  <= '0;
            pend_q     <= 1'b0;
            active_q   <= '0;
            digit_out  <= 4'd0;
            anode_n    <= '1;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
            active_q   <= active_d;

            if (load && !boundary) begin
                pending_q <= digits_in;
                pend_q    <= 1'b1;
            end
            if (commit) begin
                pend_q   <= 1'b0;
                load_ack <= 1'b1;
            end

            case (state_q)
                GUARD: begin
                    if (guard_done) begin
                        state_q    <= ACTIVE;
                        cnt_q      <= '0;
                        idx_q      <= idx_d;
                        digit_out  <= digit_d;
                        anode_n    <= dark_d[idx_d] ? '1 : ~(NUM_DIGITS'(1) << idx_d);
                        frame_tick <= boundary;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (active_done) begin
                        state_q <= GUARD;
                        cnt_q   <= '0;
                        anode_n <= '1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= GUARD;
                    cnt_q   <= '0;
                    anode_n <= '1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Randomised and directed bench for display_scan_ctrl against a
//               slot-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int ON    = 4;
    localparam int G     = 2;
    localparam int SLOT  = ON + G;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic          load = 1'b0;
    logic          lz_en = 1'b0;
    logic [N-1:0]  blank_mask = '0;
    logic [3:0]    digit_out;
    logic [N-1:0]  anode_n;
    logic          frame_tick;
    logic          load_ack;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position in the frame is derived purely from the edge count.
    int             e;
    logic [4*N-1:0] m_active, m_pending;
    logic           m_pend;
    logic [3:0]     m_digit;
    logic [N-1:0]   m_anode;
    logic           m_ft, m_ack;

    display_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .lz_en(lz_en),
        .blank_mask(blank_mask), .digit_out(digit_out), .anode_n(anode_n),
        .frame_tick(frame_tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        e = 0; m_active = '0; m_pending = '0; m_pend = 1'b0;
        m_digit = 4'd0; m_anode = '1; m_ft = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_edge();
        int s, d;
        bit dk;
        e++;
        s = e % SLOT;
        d = (e / SLOT) % N;
        m_ft = 1'b0; m_ack = 1'b0;
        if (s == G && d == 0) begin
            if (load) begin
                m_active = digits_in; m_pend = 1'b0; m_ack = 1'b1;
            end else if (m_pend) begin
                m_active = m_pending; m_pend = 1'b0; m_ack = 1'b1;
            end
            m_ft = 1'b1;
        end else if (load) begin
            m_pending = digits_in; m_pend = 1'b1;
        end
        if (s == G) begin
            m_digit = m_active[4*d +: 4];
            dk = blank_mask[d] || (lz_en && d >= 1 && (m_active >> (4*d)) == '0);
            m_anode = dk ? '1 : ~(N'(1) << d);
        end else if (s == 0) begin
            m_anode = '1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Advance until the next edge lands at frame position pos.
    task automatic skip_to(input int pos);
        for (int k = 0; k < FRAME && ((e + 1) % FRAME) != pos; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; digits_in = '0; lz_en = 1'b0; blank_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({digit_out, anode_n, frame_tick, load_ack} !== {4'd0, 4'b1111, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got digit=%h anode=%b ft=%b ack=%b, want 0 1111 0 0",
                     digit_out, anode_n, frame_tick, load_ack);
        end
    endtask

    task automatic test_first_frame();
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL first_frame e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
            if (k == 2 || k == 8) begin
                vectors++;
                if ({anode_n, frame_tick, digit_out} !== {(k == 2) ? 4'b1110 : 4'b1101, k == 2, 4'd0}) begin
                    miscompares++;
                    $display("FAIL first_lit k=%0d: got anode=%b ft=%b digit=%h", k, anode_n, frame_tick, digit_out);
                end
            end
        end
    endtask

    task automatic test_load_commit();
        bit seen = 0;
        skip_to(10);
        load = 1'b1; digits_in = 16'h4321;
        step();
        load = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL load_commit e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
            if (!seen && (e % FRAME) == G) begin
                seen = 1;
                vectors++;
                if ({digit_out, load_ack} !== {4'd1, 1'b1}) begin
                    miscompares++;
                    $display("FAIL load_commit_boundary: got digit=%h ack=%b want 1 1", digit_out, load_ack);
                end
            end
        end
    endtask

    task automatic test_collision();
        int acks = 0;
        skip_to(14);
        load = 1'b1; digits_in = 16'h1111;
        step();
        load = 1'b0;
        skip_to(G);
        load = 1'b1; digits_in = 16'h9876;
        step();
        load = 1'b0;
        vectors++;
        if ({digit_out, load_ack, frame_tick} !== {4'd6, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL collision_boundary: got digit=%h ack=%b ft=%b want 6 1 1", digit_out, load_ack, frame_tick);
        end
        for (int k = 0; k < FRAME + 2; k++) begin
            step();
            acks += int'(load_ack);
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL collision e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL collision_single_ack: got %0d extra acks want 0", acks);
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        logic [3:0]  want [2] = '{4'b0011, 4'b0001};
        lz_en = 1'b1;
        for (int v = 0; v < 2; v++) begin
            logic [N-1:0] lit = '0;
            skip_to(G);
            load = 1'b1; digits_in = vals[v];
            for (int k = 0; k < FRAME; k++) begin
                step();
                load = 1'b0;
                lit |= ~anode_n;
                vectors++;
                if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                    miscompares++;
                    $display("FAIL leading_zero e=%0d: got %h %b %b %b want %h %b %b %b", e,
                             digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
                end
            end
            vectors++;
            if (lit !== want[v]) begin
                miscompares++;
                $display("FAIL leading_zero_lit val=%h: got lit=%b want %b", vals[v], lit, want[v]);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blank_mask();
        logic [N-1:0] lit = '0;
        int t0 = -1, t1 = -1;
        blank_mask = 4'b0100;
        skip_to(G);
        load = 1'b1; digits_in = 16'h8765;
        for (int k = 0; k <= FRAME; k++) begin
            step();
            load = 1'b0;
            lit |= ~anode_n;
            if (frame_tick) begin
                if (t0 < 0) t0 = e; else t1 = e;
            end
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL blank_mask e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
        end
        vectors++;
        if (lit !== 4'b1011 || (t1 - t0) != FRAME) begin
            miscompares++;
            $display("FAIL blank_mask_frame: got lit=%b period=%0d want 1011 %0d", lit, t1 - t0, FRAME);
        end
        blank_mask = '0;
    endtask

    task automatic test_async_reset();
        skip_to(10);
        load = 1'b1; digits_in = 16'hABCD;
        step();
        load = 1'b0;
        skip_to(15);
        step();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({digit_out, anode_n, frame_tick, load_ack} !== {4'd0, 4'b1111, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got digit=%h anode=%b ft=%b ack=%b want 0 1111 0 0",
                     digit_out, anode_n, frame_tick, load_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < FRAME + 4; k++) begin
            step();
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL async_reset_after e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            load = ($urandom_range(0, 9) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 59) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 59) == 0) blank_mask = 4'($urandom);
            step();
            vectors++;
            if ({digit_out, anode_n, frame_tick, load_ack} !== {m_digit, m_anode, m_ft, m_ack}) begin
                miscompares++;
                $display("FAIL random e=%0d: got %h %b %b %b want %h %b %b %b", e,
                         digit_out, anode_n, frame_tick, load_ack, m_digit, m_anode, m_ft, m_ack);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_load_commit();
        test_collision();
        test_leading_zero();
        test_blank_mask();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
